// File: rtl/cte_pkg.sv
// Types and constants shared by the colour transform engine and its
// downstream frame writer.
package cte_pkg;

  localparam int RGB_W = 24;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fw_state_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO. Pushing while full is accepted only
// together with a pop in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LVL_FULL);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage is not reset: an entry is only visible once a push has written it.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/rgb_frame_writer.sv
// Captures one frame of RGB pixels and writes it in raster order to a
// frame-buffer SRAM through a request/grant port, buffering grant stalls.
module rgb_frame_writer
  import cte_pkg::*;
#(
  parameter int IMG_W      = 20,
  parameter int IMG_H      = 25,
  parameter int ADDR_W     = 9,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic [23:0]                   rgb_in,
  output logic                          mem_req,
  input  logic                          mem_gnt,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [23:0]                   mem_wdata,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          overflow,
  output logic                          stray,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int TOTAL = IMG_W * IMG_H;
  localparam logic [ADDR_W:0]   CNT_TOTAL = (ADDR_W+1)'(TOTAL);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [LVL_W-1:0]  LVL_ONE   = LVL_W'(1);

  fw_state_t         state_q, state_d;
  logic [ADDR_W:0]   push_cnt_q, push_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ovf_q, ovf_d;
  logic              stray_q, stray_d;

  rgb_t              pix_in_s;
  rgb_t              head_s;
  logic              fifo_full_s, fifo_empty_s;
  logic [LVL_W-1:0]  fifo_level_s;
  logic              start_go_s, accept_s, push_req_s, push_s, pop_s, drop_s, last_wr_s;

  assign pix_in_s   = rgb_in;
  assign start_go_s = (state_q == ST_IDLE) && start;
  assign accept_s   = (state_q == ST_RUN) && (push_cnt_q < CNT_TOTAL);
  assign push_req_s = in_valid && accept_s;
  assign pop_s      = mem_req && mem_gnt;
  assign push_s     = push_req_s && (!fifo_full_s || pop_s);
  assign drop_s     = push_req_s && fifo_full_s && !pop_s;
  // The frame ends when every pixel has been counted and the final buffered
  // one is being written; dropped pixels never reach the top address.
  assign last_wr_s  = pop_s && (push_cnt_q == CNT_TOTAL) && (fifo_level_s == LVL_ONE);

  sync_fifo #(
    .WIDTH (RGB_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (start_go_s),
    .push  (push_s),
    .pop   (pop_s),
    .din   (pix_in_s),
    .dout  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (fifo_level_s)
  );

  always_comb begin
    state_d    = state_q;
    push_cnt_d = push_cnt_q;
    addr_d     = addr_q;
    ovf_d      = ovf_q;
    stray_d    = stray_q;
    case (state_q)
      ST_IDLE: if (start)     state_d = ST_RUN;  else state_d = ST_IDLE;
      ST_RUN:  if (last_wr_s) state_d = ST_DONE; else state_d = ST_RUN;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (start_go_s) begin
      push_cnt_d = '0;
      addr_d     = '0;
      ovf_d      = 1'b0;
      stray_d    = 1'b0;
    end else begin
      if (push_req_s) push_cnt_d = push_cnt_q + CNT_ONE; else push_cnt_d = push_cnt_q;
      if (in_valid && !accept_s) stray_d = 1'b1; else stray_d = stray_q;
      if (drop_s) ovf_d = 1'b1; else ovf_d = ovf_q;
      // Address saturates at the last word; only a new start rewinds it.
      if (pop_s && (addr_q != LAST_ADDR)) addr_d = addr_q + ADDR_ONE; else addr_d = addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      push_cnt_q <= '0;
      addr_q     <= '0;
      ovf_q      <= 1'b0;
      stray_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      push_cnt_q <= push_cnt_d;
      addr_q     <= addr_d;
      ovf_q      <= ovf_d;
      stray_q    <= stray_d;
    end
  end

  assign mem_req    = (state_q == ST_RUN) && !fifo_empty_s;
  assign mem_addr   = addr_q;
  assign mem_wdata  = fifo_empty_s ? 24'h000000 : head_s;
  assign busy       = (state_q == ST_RUN);
  assign frame_done = (state_q == ST_DONE);
  assign overflow   = ovf_q;
  assign stray      = stray_q;
  assign fifo_level = fifo_level_s;

endmodule
